rep_dedup_serializer: RTL and testbench
=======================================

# rep_dedup_serializer

Consumes the packed group output of the repetition detector: GROUP_SIZE values plus a GROUP_SIZE×GROUP_SIZE repetition matrix. For each group it emits only the distinct values, one per cycle, in ascending index order. Each emitted value carries its leader index and a mask of every group position holding the same value. It sits directly downstream of the detector and feeds the shared-compute stage, which processes each unique value once and scatters the result by mask.

## Interface
- DATA_WIDTH, 8, width of one value
- GROUP_SIZE, 4, values per group (power of two, ≥2)
- IDX_BITS, $clog2(GROUP_SIZE), width of leader index
- LOG_MAX_GROUPS, 16, width of group-count register
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- configure  in  1  latch num_groups, clear state
- num_groups  in  LOG_MAX_GROUPS  groups per run
- data_in  in  GROUP_SIZE*DATA_WIDTH+GROUP_SIZE*GROUP_SIZE  detector output:
  - value k at [k*DATA_WIDTH +: DATA_WIDTH]
  - matrix bit (k,l) at offset GROUP_SIZE*DATA_WIDTH + k*GROUP_SIZE + l
- valid_in  in  1  data_in valid
- avail_out  out  1  ready to accept a group (to upstream)
- data_out  out  GROUP_SIZE+IDX_BITS+DATA_WIDTH  {mask, index, value}
- valid_out  out  1  data_out valid
- avail_in  in  1  downstream ready
- last_out  out  1  final unique of final group of run

## Operation
- States: IDLE (avail_out=1), EMIT (avail_out=0).
- Accept: valid_in & avail_out at an edge captures the group and moves to EMIT.
- Leader rule: position i is a leader iff no j<i has bit (i,j)=1. The diagonal is ignored, and position 0 is always a leader.
- Pending leader set is computed at capture. The lowest pending leader is presented.
- Emitted fields for leader i:
  - value = value i
  - index = i
  - mask[j] = (j==i) | bit (i,j)
- Output handshake: valid_out & avail_in clears the presented leader.
  - If leaders remain, the next one is presented on the following cycle.
  - Otherwise valid_out→0, state→IDLE, avail_out→1.
- Group counter increments when a group's last leader is accepted. It wraps to 0 after num_groups-1.
- last_out=1 only with the last leader of group num_groups-1. With num_groups=0, last_out is never asserted and the counter wraps at 2^LOG_MAX_GROUPS.
- configure (priority over valid_in and the output handshake):
  - latch num_groups, clear the counter
  - discard any pending group
  - next cycle: valid_out=0, state=IDLE, avail_out=1
- Asymmetric or non-transitive matrices are not checked. The output follows the leader and mask rules literally.

## Timing
- Reset values: valid_out=0, data_out=0, last_out=0, avail_out=0, state=IDLE, group counter=0, num_groups=0.
- avail_out rises on the first edge after rst deasserts.
- Latency: capture at edge E0 → valid_out=1 with the first leader after E0.
- A group with u leaders whose outputs are accepted at consecutive edges E1..Eu has avail_out=1 after Eu. Throughput is one group per u+1 cycles.
- All outputs are registered. data_out, valid_out and last_out are held stable while valid_out & !avail_in.
- rst mid-emission: the group is dropped and all outputs take their reset values next cycle.

## Configuration
- REP_DEDUP_STATS_EN defined: adds two outputs, both cleared by rst and configure:
  - stat_groups (32 bit): groups fully emitted
  - stat_uniques (32 bit): leaders accepted downstream
- REP_DEDUP_STATS_EN undefined: these ports and counters are absent. All other behaviour is identical.

## Test plan
- Reset and ready timing: hold rst for 2 cycles → all outputs 0. One cycle after release, avail_out=1.
- All-equal group: values {5,5,5,5}, matrix 16'hFFFF → exactly one output. data_out = value 5, index 0, mask 4'b1111. avail_out=1 the cycle after it is accepted.
- All-distinct group: values {0,1,2,3}, matrix 16'h8421 → four outputs on consecutive cycles with avail_in=1.
  - indices 0,1,2,3
  - masks 0001, 0010, 0100, 1000
- Backpressure: values {7,9,7,9}, matrix 16'hA5A5.
  - Two outputs: (7, 0, 0101) then (9, 1, 1010).
  - Hold avail_in=0 for 3 cycles during the first output → data_out unchanged and valid_out held.
- Run boundary: configure num_groups=2, then send 3 identity-matrix groups.
  - last_out=1 only on index 3 of group 2.
  - Group 3 has last_out=0 throughout.
  - With stats enabled: stat_groups=3, stat_uniques=12.
- Configure mid-emission: assert configure while index 1 of an identity group is presented → valid_out=0 next cycle, avail_out=1, remaining leaders never appear.

Source files
------------

// File: rtl/rep_dedup_serializer_if.sv
// Valid/avail handshake bundle used on both sides of rep_dedup_serializer.
// The producer drives valid/data/last; the consumer drives avail.
interface rep_dedup_serializer_if #(
  parameter int unsigned WIDTH = 8
);
  logic             valid;
  logic [WIDTH-1:0] data;
  logic             avail;
  logic             last;

  modport master (output valid, output data, output last, input avail);
  modport slave  (input valid, input data, input last, output avail);
endinterface

// File: rtl/rep_dedup_serializer.sv
// Serializes the distinct (leader) values of each detector group, one per cycle, with mask.
// Optional statistics counters are compiled in when REP_DEDUP_STATS_EN is defined.
module rep_dedup_serializer #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned GROUP_SIZE     = 4,
  parameter int unsigned IDX_BITS       = $clog2(GROUP_SIZE),
  parameter int unsigned LOG_MAX_GROUPS = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_configure,
  input  logic [LOG_MAX_GROUPS-1:0] i_num_groups,
  rep_dedup_serializer_if.slave     i_grp,
  rep_dedup_serializer_if.master    o_uniq
`ifdef REP_DEDUP_STATS_EN
  ,
  output logic [31:0]               o_stat_groups,
  output logic [31:0]               o_stat_uniques
`endif
);

  localparam int unsigned OutW   = GROUP_SIZE + IDX_BITS + DATA_WIDTH;
  localparam int unsigned MatOff = GROUP_SIZE * DATA_WIDTH;

  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  state_e                                   r_state, w_state_d;
  logic [GROUP_SIZE-1:0][DATA_WIDTH-1:0]    r_values, w_values_d;
  logic [GROUP_SIZE-1:0][GROUP_SIZE-1:0]    r_rows, w_rows_d;
  logic [GROUP_SIZE-1:0]                    r_pending, w_pending_d;
  logic                                     r_valid, w_valid_d;
  logic [OutW-1:0]                          r_data, w_data_d;
  logic                                     r_last, w_last_d;
  logic                                     r_avail, w_avail_d;
  logic [LOG_MAX_GROUPS-1:0]                r_grp_cnt, w_grp_cnt_d;
  logic [LOG_MAX_GROUPS-1:0]                r_num_groups, w_num_groups_d;

  logic [GROUP_SIZE-1:0][DATA_WIDTH-1:0]    w_in_values;
  logic [GROUP_SIZE-1:0][GROUP_SIZE-1:0]    w_in_rows;
  logic [GROUP_SIZE-1:0]                    w_in_leaders;
  logic                                     w_capture;
  logic                                     w_uniq_acc;
  logic                                     w_grp_done;
  logic                                     w_cnt_at_end;
  logic [GROUP_SIZE-1:0]                    w_sel_set;
  logic [GROUP_SIZE-1:0][DATA_WIDTH-1:0]    w_sel_values;
  logic [GROUP_SIZE-1:0][GROUP_SIZE-1:0]    w_sel_rows;
  logic [IDX_BITS-1:0]                      w_sel_idx;
  logic [GROUP_SIZE-1:0]                    w_sel_mask;
  logic [GROUP_SIZE-1:0]                    w_sel_rest;
  logic [OutW-1:0]                          w_sel_data;
  logic                                     w_sel_last;

  // Unpack the detector word and find leaders: no earlier position marked equal.
  always_comb begin
    w_in_values  = '0;
    w_in_rows    = '0;
    w_in_leaders = '0;
    for (int k = 0; k < GROUP_SIZE; k++) begin
      w_in_values[k] = i_grp.data[k*DATA_WIDTH +: DATA_WIDTH];
      w_in_rows[k]   = i_grp.data[MatOff + k*GROUP_SIZE +: GROUP_SIZE];
    end
    for (int i = 0; i < GROUP_SIZE; i++) begin
      w_in_leaders[i] = 1'b1;
      for (int j = 0; j < i; j++) begin
        if (w_in_rows[i][j]) w_in_leaders[i] = 1'b0;
      end
    end
  end

  assign w_capture    = (r_state == StIdle) && i_grp.valid && r_avail;
  assign w_uniq_acc   = !i_configure && (r_state == StEmit) && r_valid && o_uniq.avail;
  assign w_grp_done   = w_uniq_acc && (r_pending == '0);
  assign w_cnt_at_end = (r_num_groups != '0) &&
                        (r_grp_cnt == r_num_groups - LOG_MAX_GROUPS'(1));

  // One shared presenter: fresh group on capture, otherwise the remaining leaders.
  always_comb begin
    w_sel_set    = w_capture ? w_in_leaders : r_pending;
    w_sel_values = w_capture ? w_in_values  : r_values;
    w_sel_rows   = w_capture ? w_in_rows    : r_rows;
    w_sel_idx    = '0;
    for (int i = GROUP_SIZE - 1; i >= 0; i--) begin
      if (w_sel_set[i]) w_sel_idx = IDX_BITS'(i);
    end
    w_sel_mask = w_sel_rows[w_sel_idx] | (GROUP_SIZE'(1) << w_sel_idx);
    w_sel_rest = w_sel_set & ~(GROUP_SIZE'(1) << w_sel_idx);
    w_sel_data = {w_sel_mask, w_sel_idx, w_sel_values[w_sel_idx]};
    w_sel_last = (w_sel_rest == '0) && w_cnt_at_end;
  end

  always_comb begin
    w_state_d      = r_state;
    w_values_d     = r_values;
    w_rows_d       = r_rows;
    w_pending_d    = r_pending;
    w_valid_d      = r_valid;
    w_data_d       = r_data;
    w_last_d       = r_last;
    w_avail_d      = r_avail;
    w_grp_cnt_d    = r_grp_cnt;
    w_num_groups_d = r_num_groups;
    if (i_configure) begin
      w_num_groups_d = i_num_groups;
      w_grp_cnt_d    = '0;
      w_pending_d    = '0;
      w_valid_d      = 1'b0;
      w_last_d       = 1'b0;
      w_avail_d      = 1'b1;
      w_state_d      = StIdle;
    end else begin
      unique case (r_state)
        StIdle: begin
          w_avail_d = 1'b1;
          if (w_capture) begin
            w_values_d  = w_in_values;
            w_rows_d    = w_in_rows;
            w_pending_d = w_sel_rest;
            w_valid_d   = 1'b1;
            w_data_d    = w_sel_data;
            w_last_d    = w_sel_last;
            w_avail_d   = 1'b0;
            w_state_d   = StEmit;
          end
        end
        StEmit: begin
          if (w_uniq_acc) begin
            if (r_pending != '0) begin
              w_pending_d = w_sel_rest;
              w_data_d    = w_sel_data;
              w_last_d    = w_sel_last;
            end else begin
              w_valid_d   = 1'b0;
              w_last_d    = 1'b0;
              w_avail_d   = 1'b1;
              w_state_d   = StIdle;
              // num_groups == 0 falls through to natural 2^LOG_MAX_GROUPS wrap.
              w_grp_cnt_d = w_cnt_at_end ? '0 : r_grp_cnt + LOG_MAX_GROUPS'(1);
            end
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_values     <= '0;
      r_rows       <= '0;
      r_pending    <= '0;
      r_valid      <= 1'b0;
      r_data       <= '0;
      r_last       <= 1'b0;
      r_avail      <= 1'b0;
      r_grp_cnt    <= '0;
      r_num_groups <= '0;
    end else begin
      r_state      <= w_state_d;
      r_values     <= w_values_d;
      r_rows       <= w_rows_d;
      r_pending    <= w_pending_d;
      r_valid      <= w_valid_d;
      r_data       <= w_data_d;
      r_last       <= w_last_d;
      r_avail      <= w_avail_d;
      r_grp_cnt    <= w_grp_cnt_d;
      r_num_groups <= w_num_groups_d;
    end
  end

  assign i_grp.avail  = r_avail;
  assign o_uniq.valid = r_valid;
  assign o_uniq.data  = r_data;
  assign o_uniq.last  = r_last;

`ifdef REP_DEDUP_STATS_EN
  logic [31:0] r_stat_groups;
  logic [31:0] r_stat_uniques;

  always_ff @(posedge clk) begin
    if (rst || i_configure) begin
      r_stat_groups  <= '0;
      r_stat_uniques <= '0;
    end else begin
      if (w_uniq_acc) r_stat_uniques <= r_stat_uniques + 32'd1;
      if (w_grp_done) r_stat_groups  <= r_stat_groups + 32'd1;
    end
  end

  assign o_stat_groups  = r_stat_groups;
  assign o_stat_uniques = r_stat_uniques;
`endif

endmodule

// File: tb/tb_rep_dedup_serializer.sv
// Directed bench for rep_dedup_serializer with a queue-based reference model and
// a per-cycle output checker.
module tb_rep_dedup_serializer;

  localparam int unsigned DW   = 8;
  localparam int unsigned G    = 4;
  localparam int unsigned IB   = 2;
  localparam int unsigned LMG  = 16;
  localparam int unsigned MAT  = G * DW;
  localparam int unsigned IN_W = G * DW + G * G;
  localparam int unsigned OW   = G + IB + DW;

  typedef struct {
    logic [OW-1:0] data;
    logic          last;
  } exp_t;

  logic clk;
  logic rst;
  logic cfg;
  logic [LMG-1:0] num_groups;

  rep_dedup_serializer_if #(.WIDTH(IN_W)) grp_if ();
  rep_dedup_serializer_if #(.WIDTH(OW))   out_if ();

`ifdef REP_DEDUP_STATS_EN
  logic [31:0] stat_groups;
  logic [31:0] stat_uniques;
`endif

  rep_dedup_serializer #(
    .DATA_WIDTH     (DW),
    .GROUP_SIZE     (G),
    .IDX_BITS       (IB),
    .LOG_MAX_GROUPS (LMG)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_configure    (cfg),
    .i_num_groups   (num_groups),
    .i_grp          (grp_if),
    .o_uniq         (out_if)
`ifdef REP_DEDUP_STATS_EN
    ,
    .o_stat_groups  (stat_groups),
    .o_stat_uniques (stat_uniques)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  exp_t exp_q[$];
  int   m_ng  = 0;
  int   m_cnt = 0;
  bit   flush = 1'b0;
  int   last_seen = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [IN_W-1:0] pack(input logic [7:0] v0, input logic [7:0] v1,
                                           input logic [7:0] v2, input logic [7:0] v3,
                                           input logic [15:0] m);
    return {m, v3, v2, v1, v0};
  endfunction

  // Reference: distinct values in index order, mask = self plus every marked position.
  task automatic model_push(input logic [IN_W-1:0] din);
    int       lead[$];
    bit       is_l;
    int       i;
    logic [G-1:0] mask;
    exp_t     e;
    for (int p = 0; p < G; p++) begin
      is_l = 1'b1;
      for (int j = 0; j < p; j++) if (din[MAT + p*G + j]) is_l = 1'b0;
      if (is_l) lead.push_back(p);
    end
    for (int n = 0; n < lead.size(); n++) begin
      i = lead[n];
      for (int j = 0; j < G; j++) mask[j] = (j == i) || din[MAT + i*G + j];
      e.data = {mask, IB'(i), din[i*DW +: DW]};
      e.last = (n == lead.size() - 1) && (m_ng != 0) && (m_cnt == m_ng - 1);
      exp_q.push_back(e);
    end
    if (m_ng != 0 && m_cnt == m_ng - 1) m_cnt = 0;
    else m_cnt = (m_cnt + 1) % (1 << LMG);
  endtask

  // Output checker: compare on every handshake, verify stability during stalls.
  bit            hold_active = 1'b0;
  logic [OW-1:0] held_data;
  logic          held_last;
  exp_t          cur;

  always @(negedge clk) begin
    if (rst || flush) begin
      hold_active = 1'b0;
    end else begin
      if (hold_active) begin
        chk("hold_valid", out_if.valid, 1'b1);
        chk("hold_data", {out_if.data, out_if.last}, {held_data, held_last});
      end
      if (out_if.valid && out_if.avail) begin
        hold_active = 1'b0;
        if (out_if.last) last_seen++;
        if (exp_q.size() == 0) begin
          chk("unexpected_output", out_if.data, '0);
          chk("unexpected_valid", out_if.valid, 1'b0);
        end else begin
          cur = exp_q.pop_front();
          chk("out_data", out_if.data, cur.data);
          chk("out_last", out_if.last, cur.last);
        end
      end else if (out_if.valid) begin
        hold_active = 1'b1;
        held_data   = out_if.data;
        held_last   = out_if.last;
      end else begin
        hold_active = 1'b0;
      end
    end
  end

  task automatic wait_avail();
    int n = 0;
    while (!grp_if.avail && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_avail", grp_if.avail, 1'b1);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_if.valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_valid", out_if.valid, 1'b1);
  endtask

  task automatic send(input logic [IN_W-1:0] din);
    wait_avail();
    model_push(din);
    grp_if.valid = 1'b1;
    grp_if.data  = din;
    @(posedge clk); #1;
    grp_if.valid = 1'b0;
  endtask

  task automatic configure(input int ng);
    cfg        = 1'b1;
    num_groups = LMG'(ng);
    @(posedge clk); #1;
    cfg = 1'b0;
    m_ng  = ng;
    m_cnt = 0;
    exp_q.delete();
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || !grp_if.avail) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  logic [IN_W-1:0] din;

  initial begin
    rst          = 1'b1;
    cfg          = 1'b0;
    num_groups   = '0;
    grp_if.valid = 1'b0;
    grp_if.data  = '0;
    grp_if.last  = 1'b0;
    out_if.avail = 1'b1;

    // Reset values and avail timing.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_if.valid, 1'b0);
    chk("rst_data", out_if.data, '0);
    chk("rst_last", out_if.last, 1'b0);
    chk("rst_avail", grp_if.avail, 1'b0);
    rst = 1'b0;
    #1;
    chk("avail_before_edge", grp_if.avail, 1'b0);
    @(posedge clk); #1;
    chk("avail_after_release", grp_if.avail, 1'b1);

    // All-equal group: one output.
    din = pack(8'd5, 8'd5, 8'd5, 8'd5, 16'hFFFF);
    send(din);
    chk("eq_model_size", exp_q.size(), 1);
    chk("eq_latency_valid", out_if.valid, 1'b1);
    chk("eq_data", out_if.data, {4'b1111, 2'd0, 8'd5});
    @(posedge clk); #1;
    chk("eq_valid_done", out_if.valid, 1'b0);
    chk("eq_avail_back", grp_if.avail, 1'b1);

    // All-distinct group: four outputs on consecutive cycles.
    din = pack(8'd0, 8'd1, 8'd2, 8'd3, 16'h8421);
    send(din);
    chk("dist_model_size", exp_q.size(), 4);
    for (int k = 0; k < 4; k++) begin
      chk("dist_valid", out_if.valid, 1'b1);
      chk("dist_index", out_if.data[DW +: IB], k);
      chk("dist_mask", out_if.data[DW+IB +: G], 1 << k);
      @(posedge clk); #1;
    end
    chk("dist_done", out_if.valid, 1'b0);
    chk("dist_avail", grp_if.avail, 1'b1);

    // Backpressure on the first of two outputs.
    din = pack(8'd7, 8'd9, 8'd7, 8'd9, 16'hA5A5);
    out_if.avail = 1'b0;
    send(din);
    chk("bp_model_size", exp_q.size(), 2);
    chk("bp_model_second", exp_q[1].data, {4'b1010, 2'd1, 8'd9});
    repeat (3) begin
      chk("bp_hold_valid", out_if.valid, 1'b1);
      chk("bp_hold_data", out_if.data, {4'b0101, 2'd0, 8'd7});
      @(posedge clk); #1;
    end
    out_if.avail = 1'b1;
    @(posedge clk); #1;
    chk("bp_second", out_if.data, {4'b1010, 2'd1, 8'd9});
    @(posedge clk); #1;
    chk("bp_done", out_if.valid, 1'b0);

    // Run boundary: num_groups = 2, three identity groups.
    configure(2);
    chk("cfg_avail", grp_if.avail, 1'b1);
    last_seen = 0;
    send(pack(8'd1, 8'd2, 8'd3, 8'd4, 16'h8421));
    send(pack(8'd5, 8'd6, 8'd7, 8'd8, 16'h8421));
    send(pack(8'd9, 8'd10, 8'd11, 8'd12, 16'h8421));
    drain();
    chk("run_last_count", last_seen, 1);
`ifdef REP_DEDUP_STATS_EN
    chk("stat_groups", stat_groups, 3);
    chk("stat_uniques", stat_uniques, 12);
`endif

    // Configure while index 1 is presented.
    send(pack(8'd20, 8'd21, 8'd22, 8'd23, 16'h8421));
    @(posedge clk); #1;
    chk("mid_index1", out_if.data[DW +: IB], 1);
    out_if.avail = 1'b0;
    flush = 1'b1;
    configure(2);
    chk("mid_valid_off", out_if.valid, 1'b0);
    chk("mid_avail_on", grp_if.avail, 1'b1);
    out_if.avail = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    repeat (4) begin
      chk("mid_no_more", out_if.valid, 1'b0);
      @(posedge clk); #1;
    end
`ifdef REP_DEDUP_STATS_EN
    chk("mid_stat_cleared", stat_uniques, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
